// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_t : controller state encoding (IDLE / RUN / DONE)
//   W_DEF   : default operand/sum width
//   CW_DEF  : default bit-index counter width (2**CW_DEF >= W_DEF)
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int W_DEF  = 8;
  localparam int CW_DEF = 5;

endpackage

// File: rtl/serial_add_ctrl_fa_dec_cell.sv
// fa_dec_cell: combinational 1-bit full adder built from a 3-to-8
// active-low decoder whose selected minterms are ORed together.
//   x, y : addend bits
//   z    : carry in
//   s    : sum      (minterms 1,2,4,7)
//   co   : carry out (minterms 3,5,6,7)
module fa_dec_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);

  logic [2:0] sel;
  logic [7:0] dec_n;

  assign sel = {x, y, z};

  for (genvar i = 0; i < 8; i++) begin : g_dec
    assign dec_n[i] = (sel != 3'(i));
  end

  assign s  = ~dec_n[1] | ~dec_n[2] | ~dec_n[4] | ~dec_n[7];
  assign co = ~dec_n[3] | ~dec_n[5] | ~dec_n[6] | ~dec_n[7];

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. Captures two W-bit operands
// on an accepted start and streams one bit pair per clock (LSB first)
// through a single fa_dec_cell, carrying between cycles.
//   clk, rst     : clock (rising edge), async active-high reset
//   start        : request, accepted only while ready
//   a, b, ci     : operands and carry-in, captured on accept
//   sub          : (SERIAL_ADD_CTRL_SUB_EN only) subtract, sum = a - b
//   ready        : IDLE or DONE, a start will be accepted
//   busy         : bits are being processed
//   done         : one-cycle pulse, sum/co valid
//   sum, co      : result, held until the next completed operation
// Optional feature macro: SERIAL_ADD_CTRL_SUB_EN
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic         sub,
`endif
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         co
);

  state_t        state, state_nxt;
  logic [W-1:0]  a_sr, b_sr, s_sr;
  logic          cy;
  logic [CW-1:0] cnt;
  logic          fa_s, fa_co;
  logic          accept, last;
  logic [W-1:0]  b_cap;
  logic          cy_cap;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  // Two's complement subtract: a + ~b + 1; ci is ignored when subtracting.
  assign b_cap  = sub ? ~b : b;
  assign cy_cap = sub ? 1'b1 : ci;
`else
  assign b_cap  = b;
  assign cy_cap = ci;
`endif

  assign last = (cnt == CW'(W - 1));

  fa_dec_cell u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .z  (cy),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Back-to-back start is taken straight from DONE.
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ready = (state == ST_IDLE) || (state == ST_DONE);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      cy   <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      co   <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b_cap;
      cy   <= cy_cap;
      s_sr <= '0;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      // Sum bits enter at the MSB; after W shifts bit 0 sits at the LSB.
      s_sr <= {fa_s, s_sr[W-1:1]};
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      cy   <= fa_co;
      cnt  <= cnt + 1'b1;
      if (last) begin
        sum <= {fa_s, s_sr[W-1:1]};
        co  <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, ci8, start4, ci4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       ready8, busy8, done8, co8;
  logic       ready4, busy4, done4, co4;
  logic [7:0] sum8;
  logic [3:0] sum4;
`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic       sub8 = 1'b0;
  logic       sub4 = 1'b0;
`endif

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q4[$];
  logic [8:0] last8;
  logic [4:0] last4;

  serial_add_ctrl #(.W(8), .CW(5)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub(sub8),
`endif
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_add_ctrl #(.W(4), .CW(3)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub(sub4),
`endif
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .co(co4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitors: pop on every done pulse, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) last8 = '0;
    else if (done8) begin
      if (q8.size() == 0) flag("unexpected_done8");
      else begin
        e = q8.pop_front();
        chk("sum8", {co8, sum8}, {e.co, e.sum[7:0]});
        chk("latency8", cyc, e.due);
        chk("ready_busy_in_done8", {ready8, busy8}, 2'b10);
      end
      last8 = {co8, sum8};
    end else chk("hold8", {co8, sum8}, last8);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) last4 = '0;
    else if (done4) begin
      if (q4.size() == 0) flag("unexpected_done4");
      else begin
        e = q4.pop_front();
        chk("sum4", {co4, sum4}, {e.co, e.sum[3:0]});
        chk("latency4", cyc, e.due);
      end
      last4 = {co4, sum4};
    end else chk("hold4", {co4, sum4}, last4);
  end

  // bb=1: caller is already at a negedge with ready high (back-to-back).
  task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input logic [8:0] ex, input bit bb);
    exp_t e;
    int n = 0;
    if (!bb) begin
      @(negedge clk);
      while (!ready8 && n < 40) begin @(negedge clk); n++; end
      if (!ready8) begin flag("timeout_ready8"); return; end
    end
    a8 = ia; b8 = ib; ci8 = ic; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e.sum = {24'd0, ex[7:0]}; e.co = ex[8]; e.due = cyc + 8;
    q8.push_back(e);
  endtask

  task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    exp_t e;
    logic [4:0] r;
    int n = 0;
    @(negedge clk);
    while (!ready4 && n < 40) begin @(negedge clk); n++; end
    if (!ready4) begin flag("timeout_ready4"); return; end
    a4 = ia; b4 = ib; ci4 = ic; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    r = 5'(ia) + 5'(ib) + 5'(ic);
    e.sum = {28'd0, r[3:0]}; e.co = r[4]; e.due = cyc + 4;
    q4.push_back(e);
  endtask

  task automatic wait_done8();
    int n = 0;
    @(negedge clk);
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    if (!done8) flag("timeout_done8");
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    #12;
    chk("rst_ready8", ready8, 1'b1);
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum8", {co8, sum8}, 9'h000);
    chk("rst_ready4", {ready4, busy4, done4}, 3'b100);
    rst = 1'b0;

    // Basic add and carry cases
    issue8(8'h5A, 8'h3C, 1'b0, 9'h096, 0);
    issue8(8'hFF, 8'h01, 1'b0, 9'h100, 0);
    issue8(8'hFF, 8'h00, 1'b1, 9'h100, 0);
    issue8(8'h00, 8'h00, 1'b1, 9'h001, 0);

    // Start while busy is ignored, then back-to-back from DONE
    issue8(8'h01, 8'h02, 1'b0, 9'h003, 0);
    repeat (2) @(negedge clk);
    chk("busy_mid_run", {ready8, busy8}, 2'b01);
    a8 = 8'hF0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8();
    issue8(8'h10, 8'h20, 1'b0, 9'h030, 1);
    @(negedge clk);
    chk("b2b_busy", {ready8, busy8, done8}, 3'b010);

    // Reset in the middle of RUN: abandoned, outputs cleared at once
    wait_done8();
    issue8(8'h55, 8'h33, 1'b0, 9'h088, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_ready", ready8, 1'b1);
    chk("midrst_sum", {co8, sum8}, 9'h000);
    q8.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    issue8(8'h07, 8'h09, 1'b0, 9'h010, 0);

`ifdef SERIAL_ADD_CTRL_SUB_EN
    wait_done8();
    sub8 = 1'b1;
    issue8(8'h10, 8'h01, 1'b0, 9'h10F, 0);
    issue8(8'h01, 8'h02, 1'b1, 9'h0FF, 0);
    wait_done8();
    sub8 = 1'b0;
    issue8(8'h01, 8'h02, 1'b1, 9'h004, 0);
`endif

    // Exhaustive W=4 sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue4(4'(ia), 4'(ib), 1'(ic));

    n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk("queues_drained", q8.size() + q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
